mod_n_counter_rt: RTL and testbench



---
 rtl/mod_n_counter_rt_pkg.sv | 20 ++
 rtl/mod_n_counter_rt_if.sv | 32 +++
 rtl/mod_n_counter_rt_tick_prescaler.sv | 41 ++++
 rtl/mod_n_counter_rt.sv | 81 ++++++++
 tb/tb_mod_n_counter_rt.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_n_counter_rt_pkg.sv
`default_nettype none
// ============================================================================
// rt_counter_pkg : default rates/moduli and direction type for RT counters
// Rev 1.0
// ============================================================================
package rt_counter_pkg;

   localparam int CLK_FREQ_HZ = 50_000_000;
   localparam int TICK_HZ     = 1;
   localparam int N_SEC       = 60;
   localparam int N_MIN       = 60;
   localparam int N_HOUR      = 24;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } count_dir_e;

endpackage : rt_counter_pkg
`default_nettype wire

// File: rtl/mod_n_counter_rt_if.sv
`default_nettype none
// ============================================================================
// mod_n_counter_rt_if : control/status bundle of one modulo-N digit stage
// Rev 1.0
// ============================================================================
interface mod_n_counter_rt_if #(
   parameter int N = 60,
   parameter int W = $clog2(N)
);

   logic         en;
   logic         clr;
   logic         load;
   logic [W-1:0] load_val;
   logic         up_dn;
   logic [W-1:0] count;
   logic         tick_o;
   logic         carry_o;
   logic         tc;

   modport master (
      output en, clr, load, load_val, up_dn,
      input  count, tick_o, carry_o, tc
   );

   modport slave (
      input  en, clr, load, load_val, up_dn,
      output count, tick_o, carry_o, tc
   );

endinterface : mod_n_counter_rt_if
`default_nettype wire

// File: rtl/mod_n_counter_rt_tick_prescaler.sv
`default_nettype none
// ============================================================================
// tick_prescaler : divides clk down to a one-cycle step at TICK_HZ
// Rev 1.0
// ============================================================================
module tick_prescaler #(
   parameter int CLK_FREQ_HZ = rt_counter_pkg::CLK_FREQ_HZ,
   parameter int TICK_HZ     = rt_counter_pkg::TICK_HZ
) (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic en,
   input  wire logic clr,
   output logic      step
);

   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
   // With DIV = 1 the single-bit register stays at 0, so step simply follows en.
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   if (DIV < 1) begin : g_div_check
      $error("tick_prescaler: CLK_FREQ_HZ/TICK_HZ must be >= 1");
   end

   logic [PW-1:0] pre;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre <= '0;
      end else if (clr) begin
         pre <= '0;
      end else if (en) begin
         pre <= (pre == LAST) ? '0 : pre + PW'(1);
      end
   end

   assign step = en && (pre == LAST);

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/mod_n_counter_rt.sv
`default_nettype none
// ============================================================================
// mod_n_counter_rt : prescaled modulo-N up/down digit counter with carry out
// Rev 1.0
// ============================================================================
module mod_n_counter_rt #(
   parameter int CLK_FREQ_HZ = rt_counter_pkg::CLK_FREQ_HZ,
   parameter int TICK_HZ     = rt_counter_pkg::TICK_HZ,
   parameter int N           = rt_counter_pkg::N_SEC
) (
   input  wire logic          clk,
   input  wire logic          reset,
   mod_n_counter_rt_if.slave  bus
);

   import rt_counter_pkg::*;

   localparam int W = $clog2(N);
   localparam logic [W-1:0] MAX = W'(N - 1);

   if (N < 2) begin : g_n_check
      $error("mod_n_counter_rt: N must be >= 2");
   end

   logic         step;
   logic [W-1:0] cnt;
   logic         tick;
   logic         carry;
   logic [W-1:0] load_clamped;
   count_dir_e   dir;

   tick_prescaler #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .TICK_HZ     (TICK_HZ)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (bus.en),
      .clr   (bus.clr),
      .step  (step)
   );

   assign dir          = count_dir_e'(bus.up_dn);
   // Loads above N-1 saturate so count can never leave the 0..N-1 range.
   assign load_clamped = (bus.load_val > MAX) ? MAX : bus.load_val;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         tick  <= 1'b0;
         carry <= 1'b0;
      end else if (bus.clr) begin
         cnt   <= '0;
         tick  <= 1'b0;
         carry <= 1'b0;
      end else if (bus.load) begin
         cnt   <= load_clamped;
         tick  <= 1'b0;
         carry <= 1'b0;
      end else if (step) begin
         tick <= 1'b1;
         if (dir == DIR_UP) begin
            carry <= (cnt == MAX);
            cnt   <= (cnt == MAX) ? '0 : cnt + W'(1);
         end else begin
            carry <= (cnt == '0);
            cnt   <= (cnt == '0) ? MAX : cnt - W'(1);
         end
      end else begin
         tick  <= 1'b0;
         carry <= 1'b0;
      end
   end

   assign bus.count   = cnt;
   assign bus.tick_o  = tick;
   assign bus.carry_o = carry;
   assign bus.tc      = (dir == DIR_UP) ? (cnt == MAX) : (cnt == '0);

endmodule : mod_n_counter_rt
`default_nettype wire

// File: tb/tb_mod_n_counter_rt.sv
`default_nettype none
// ============================================================================
// tb_mod_n_counter_rt : directed bench, DIV = 10 and DIV = 1 instances, N = 6
// Rev 1.0
// ============================================================================
module tb_mod_n_counter_rt;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mod_n_counter_rt_if #(.N(6)) bus1 ();
   mod_n_counter_rt_if #(.N(6)) bus2 ();

   mod_n_counter_rt #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .N(6)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   mod_n_counter_rt #(.CLK_FREQ_HZ(10), .TICK_HZ(10), .N(6)) u_dut_div1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle 1 time unit past it.
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus1.en = 1'b0; bus1.clr = 1'b0; bus1.load = 1'b0; bus1.load_val = '0; bus1.up_dn = 1'b1;
      bus2.en = 1'b0; bus2.clr = 1'b0; bus2.load = 1'b0; bus2.load_val = '0; bus2.up_dn = 1'b1;
      repeat (3) edge1();
      checks++;
      if (bus1.count !== 3'd0 || bus1.tick_o !== 1'b0 || bus1.carry_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: count=%0d tick=%b carry=%b, want 0/0/0",
                  bus1.count, bus1.tick_o, bus1.carry_o);
      end
      checks++;
      if (bus1.tc !== 1'b0) begin
         errors++; $display("FAIL reset_tc_up: tc=%b want 0", bus1.tc);
      end
      bus1.up_dn = 1'b0;
      #1;
      checks++;
      if (bus1.tc !== 1'b1) begin
         errors++; $display("FAIL reset_tc_down: tc=%b want 1", bus1.tc);
      end
      bus1.up_dn = 1'b1;
      checks++;
      if (bus2.count !== 3'd0 || bus2.tick_o !== 1'b0) begin
         errors++; $display("FAIL reset_div1: count=%0d tick=%b want 0/0", bus2.count, bus2.tick_o);
      end
   endtask

   task automatic test_up_count();
      logic [2:0] exp_cnt;
      bus1.en = 1'b1;
      reset   = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         edge1();
         exp_cnt = 3'((i / 10) % 6);
         checks++;
         if (bus1.tick_o !== (i % 10 == 0) || bus1.count !== exp_cnt) begin
            errors++;
            $display("FAIL up_seq cycle %0d: tick=%b count=%0d, want tick=%b count=%0d",
                     i, bus1.tick_o, bus1.count, (i % 10 == 0), exp_cnt);
         end
         checks++;
         if (bus1.carry_o !== (i == 60) || bus1.tc !== (exp_cnt == 3'd5)) begin
            errors++;
            $display("FAIL up_carry_tc cycle %0d: carry=%b tc=%b, want %b/%b",
                     i, bus1.carry_o, bus1.tc, (i == 60), (exp_cnt == 3'd5));
         end
      end
   endtask

   task automatic test_down_count();
      logic [2:0] exp_seq [3];
      exp_seq[0] = 3'd5; exp_seq[1] = 3'd4; exp_seq[2] = 3'd3;
      bus1.up_dn = 1'b0;
      #1;
      checks++;
      if (bus1.tc !== 1'b1) begin
         errors++; $display("FAIL down_tc_at0: tc=%b want 1", bus1.tc);
      end
      for (int s = 0; s < 3; s++) begin
         repeat (10) edge1();
         checks++;
         if (bus1.tick_o !== 1'b1 || bus1.count !== exp_seq[s] ||
             bus1.carry_o !== (s == 0) || bus1.tc !== 1'b0) begin
            errors++;
            $display("FAIL down_step %0d: tick=%b count=%0d carry=%b tc=%b, want 1/%0d/%b/0",
                     s, bus1.tick_o, bus1.count, bus1.carry_o, bus1.tc, exp_seq[s], (s == 0));
         end
      end
   endtask

   task automatic test_load_clamp();
      bus1.up_dn    = 1'b1;
      bus1.load     = 1'b1;
      bus1.load_val = 3'd7;
      edge1();
      bus1.load = 1'b0;
      checks++;
      if (bus1.count !== 3'd5 || bus1.tick_o !== 1'b0) begin
         errors++; $display("FAIL load_clamp: count=%0d tick=%b want 5/0", bus1.count, bus1.tick_o);
      end
      repeat (8) edge1();
      bus1.load     = 1'b1;
      bus1.load_val = 3'd2;
      edge1();
      bus1.load = 1'b0;
      checks++;
      if (bus1.count !== 3'd2 || bus1.tick_o !== 1'b0 || bus1.carry_o !== 1'b0) begin
         errors++;
         $display("FAIL load_vs_step: count=%0d tick=%b carry=%b want 2/0/0",
                  bus1.count, bus1.tick_o, bus1.carry_o);
      end
      repeat (10) edge1();
      checks++;
      if (bus1.count !== 3'd3 || bus1.tick_o !== 1'b1) begin
         errors++; $display("FAIL load_next_tick: count=%0d tick=%b want 3/1", bus1.count, bus1.tick_o);
      end
   endtask

   task automatic test_clear_priority();
      repeat (10) edge1();
      repeat (9) edge1();
      checks++;
      if (bus1.count !== 3'd4) begin
         errors++; $display("FAIL clr_setup: count=%0d want 4", bus1.count);
      end
      bus1.clr      = 1'b1;
      bus1.load     = 1'b1;
      bus1.load_val = 3'd1;
      edge1();
      bus1.clr  = 1'b0;
      bus1.load = 1'b0;
      checks++;
      if (bus1.count !== 3'd0 || bus1.tick_o !== 1'b0 || bus1.carry_o !== 1'b0) begin
         errors++;
         $display("FAIL clr_priority: count=%0d tick=%b carry=%b want 0/0/0",
                  bus1.count, bus1.tick_o, bus1.carry_o);
      end
      for (int i = 1; i <= 10; i++) begin
         edge1();
         checks++;
         if (bus1.tick_o !== (i == 10)) begin
            errors++; $display("FAIL clr_tick_spacing cycle %0d: tick=%b want %b", i, bus1.tick_o, (i == 10));
         end
      end
      checks++;
      if (bus1.count !== 3'd1) begin
         errors++; $display("FAIL clr_resume: count=%0d want 1", bus1.count);
      end
   endtask

   task automatic test_enable_pause();
      repeat (4) edge1();
      bus1.en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         edge1();
         checks++;
         if (bus1.count !== 3'd1 || bus1.tick_o !== 1'b0) begin
            errors++; $display("FAIL pause_hold %0d: count=%0d tick=%b want 1/0", i, bus1.count, bus1.tick_o);
         end
      end
      bus1.en = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         edge1();
         checks++;
         if (bus1.tick_o !== (i == 6)) begin
            errors++; $display("FAIL pause_resume cycle %0d: tick=%b want %b", i, bus1.tick_o, (i == 6));
         end
      end
      checks++;
      if (bus1.count !== 3'd2) begin
         errors++; $display("FAIL pause_count: count=%0d want 2", bus1.count);
      end
   endtask

   task automatic test_async_reset();
      repeat (10) edge1();
      repeat (6) edge1();
      checks++;
      if (bus1.count !== 3'd3) begin
         errors++; $display("FAIL arst_setup: count=%0d want 3", bus1.count);
      end
      reset = 1'b1;
      #2;
      checks++;
      if (bus1.count !== 3'd0 || bus1.tick_o !== 1'b0 || bus1.carry_o !== 1'b0) begin
         errors++;
         $display("FAIL arst_immediate: count=%0d tick=%b carry=%b want 0/0/0",
                  bus1.count, bus1.tick_o, bus1.carry_o);
      end
      #1;
      reset = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         edge1();
         checks++;
         if (bus1.tick_o !== (i == 10)) begin
            errors++; $display("FAIL arst_restart cycle %0d: tick=%b want %b", i, bus1.tick_o, (i == 10));
         end
      end
      checks++;
      if (bus1.count !== 3'd1) begin
         errors++; $display("FAIL arst_count: count=%0d want 1", bus1.count);
      end
   endtask

   task automatic test_div1();
      bus2.en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         edge1();
         checks++;
         if (bus2.count !== 3'(i % 6) || bus2.tick_o !== 1'b1 || bus2.carry_o !== (i == 6)) begin
            errors++;
            $display("FAIL div1_step %0d: count=%0d tick=%b carry=%b want %0d/1/%b",
                     i, bus2.count, bus2.tick_o, bus2.carry_o, i % 6, (i == 6));
         end
      end
      bus2.en = 1'b0;
      repeat (2) edge1();
      checks++;
      if (bus2.count !== 3'd2 || bus2.tick_o !== 1'b0) begin
         errors++; $display("FAIL div1_hold: count=%0d tick=%b want 2/0", bus2.count, bus2.tick_o);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_up_count();
      test_down_count();
      test_load_clamp();
      test_clear_priority();
      test_enable_pause();
      test_async_reset();
      test_div1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mod_n_counter_rt
`default_nettype wire
